// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//
// Shares one single-ported BRAM port (1-cycle read latency) between NREQ
// requesters using round-robin arbitration, one access per cycle. Read data
// is routed back to the requester that was granted, with a one-cycle
// rvalid_o pulse. Writes get the same pulse with rdata_o = 0 as an ack.
//
// Optional feature (macro BRAM_ARB_LOCK_EN): adds lock_i. A winner that
// holds lock_i high at grant takes exclusive ownership of the port until
// lock_i of that owner drops; the pointer then resumes at owner+1.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   req_i                per-requester request
//   lock_i               per-requester lock (BRAM_ARB_LOCK_EN only)
//   req_we_i             per-requester byte write enables, all-zero = read
//   req_addr_i           per-requester word address
//   req_wdata_i          per-requester write data
//   gnt_o                one-hot grant, same cycle as the accepted request
//   rvalid_o             one-hot response pulse, one cycle after grant
//   rdata_o              shared response data, qualified by rvalid_o
//   bram_*               BRAM port (en/we/addr/wrdata out, rddata in)
//   dbg_ptr_o            round-robin priority pointer
//   dbg_locked_o         1 while in LOCKED state (BRAM_ARB_LOCK_EN only)
//
// Handshake: a requester raises req_i[i] with its we/addr/wdata and holds
// all of them stable until it sees gnt_o[i]=1 in the same cycle; that cycle
// is the transfer. gnt_o only ever rises on a lane whose req_i is high, and
// at most one lane is granted per cycle.
module bram_port_arbiter #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NREQ-1:0]            req_i,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NREQ-1:0]            lock_i,
`endif
  input  logic [NREQ*BE_WIDTH-1:0]   req_we_i,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NREQ-1:0]            gnt_o,
  output logic [NREQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       bram_en_o,
  output logic [BE_WIDTH-1:0]        bram_we_o,
  output logic [ADDR_WIDTH-1:0]      bram_addr_o,
  output logic [DATA_WIDTH-1:0]      bram_wrdata_o,
  input  logic [DATA_WIDTH-1:0]      bram_rddata_i,
  output logic [PTR_W-1:0]           dbg_ptr_o
`ifdef BRAM_ARB_LOCK_EN
  ,
  output logic                       dbg_locked_o
`endif
);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NREQ - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Unpacked views of the flat request buses.
  logic [BE_WIDTH-1:0]   we_arr    [NREQ];
  logic [ADDR_WIDTH-1:0] addr_arr  [NREQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      we_arr[i]    = req_we_i[i*BE_WIDTH +: BE_WIDTH];
      addr_arr[i]  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  logic [PTR_W-1:0] ptr_q;

  // Response pipeline stage.
  logic             resp_valid_q;
  logic [PTR_W-1:0] resp_idx_q;
  logic             resp_read_q;

  // Last driven address/data, held on idle cycles.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

`ifdef BRAM_ARB_LOCK_EN
  typedef enum logic {ST_RR, ST_LOCKED} lock_state_e;
  lock_state_e      state_q;
  logic [PTR_W-1:0] owner_q;
`endif

  // Round-robin search: scanning offsets from high to low leaves the
  // requester closest to the pointer as the final (winning) assignment.
  logic             rr_valid;
  logic [PTR_W-1:0] rr_idx;
  logic [PTR_W:0]   cand;

  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) cand = cand - (PTR_W+1)'(NREQ);
      if (req_i[cand[PTR_W-1:0]]) begin
        rr_valid = 1'b1;
        rr_idx   = cand[PTR_W-1:0];
      end
    end
  end

  logic                  win_valid;
  logic [PTR_W-1:0]      win_idx;
  logic [BE_WIDTH-1:0]   win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  always_comb begin
    win_valid = rr_valid;
    win_idx   = rr_idx;
`ifdef BRAM_ARB_LOCK_EN
    if (state_q == ST_LOCKED) begin
      win_valid = req_i[owner_q];
      win_idx   = owner_q;
    end
`endif
    // Grants are combinational, so they must be forced off during reset.
    if (!rst_ni) win_valid = 1'b0;
    win_we    = we_arr[win_idx];
    win_addr  = addr_arr[win_idx];
    win_wdata = wdata_arr[win_idx];
  end

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i]    = win_valid && (win_idx == PTR_W'(i));
      rvalid_o[i] = resp_valid_q && (resp_idx_q == PTR_W'(i));
    end
  end

  assign bram_en_o     = win_valid;
  assign bram_we_o     = win_valid ? win_we : '0;
  assign bram_addr_o   = win_valid ? win_addr : addr_q;
  assign bram_wrdata_o = win_valid ? win_wdata : wdata_q;

  // Write acks return zero; reads pass the BRAM output through.
  assign rdata_o   = (resp_valid_q && resp_read_q) ? bram_rddata_i : '0;
  assign dbg_ptr_o = ptr_q;
`ifdef BRAM_ARB_LOCK_EN
  assign dbg_locked_o = (state_q == ST_LOCKED);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_read_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef BRAM_ARB_LOCK_EN
      state_q      <= ST_RR;
      owner_q      <= '0;
`endif
    end else begin
      resp_valid_q <= win_valid;
      if (win_valid) begin
        resp_idx_q  <= win_idx;
        resp_read_q <= (win_we == '0);
        addr_q      <= win_addr;
        wdata_q     <= win_wdata;
      end
`ifdef BRAM_ARB_LOCK_EN
      case (state_q)
        ST_RR: begin
          if (win_valid) begin
            ptr_q <= ptr_inc(win_idx);
            if (lock_i[win_idx]) begin
              state_q <= ST_LOCKED;
              owner_q <= win_idx;
            end
          end
        end
        ST_LOCKED: begin
          // Pointer is frozen while locked; release resumes after the owner.
          if (!lock_i[owner_q]) begin
            state_q <= ST_RR;
            ptr_q   <= ptr_inc(owner_q);
          end
        end
        default: state_q <= ST_RR;
      endcase
`else
      if (win_valid) ptr_q <= ptr_inc(win_idx);
`endif
    end
  end

endmodule
